// File: rtl/id_ex_issue_ctrl_pkg.sv
// rtl/id_ex_issue_ctrl_pkg.sv - pipe_ctrl_pkg: control-word bit map, NOP word, issue FSM states
package pipe_ctrl_pkg;
    localparam int CW_ALUSRC1     = 12;
    localparam int CW_ALUSRC2     = 11;
    localparam int CW_ALUOP_HI    = 10;
    localparam int CW_ALUOP_LO    = 7;
    localparam int CW_RTRD        = 6;
    localparam int CW_MEMREAD     = 5;
    localparam int CW_MEMWRITE    = 4;
    localparam int CW_REGWRITE    = 3;
    localparam int CW_MEMTOREG_HI = 2;
    localparam int CW_MEMTOREG_LO = 1;
    localparam int CW_BRANCH      = 0;

    localparam logic [12:0] CW_NOP = 13'h0000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2
    } issue_state_e;
endpackage

// File: rtl/id_ex_issue_ctrl_if.sv
// rtl/id_ex_issue_ctrl_if.sv - ID instruction in / ID-EX control word out bundle
interface id_ex_issue_ctrl_if #(
    parameter int CW_W  = 13,
    parameter int REG_W = 5
);
    logic             id_valid;
    logic [CW_W-1:0]  id_ctrl_in;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [CW_W-1:0]  ex_ctrl_out;
    logic             bubble;

    modport master (
        output id_valid, id_ctrl_in, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
        input  ex_ctrl_out, bubble
    );

    modport slave (
        input  id_valid, id_ctrl_in, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
        output ex_ctrl_out, bubble
    );
endinterface

// File: rtl/id_ex_hazard_cmp.sv
// rtl/id_ex_hazard_cmp.sv - load-use compare of ID source regs against last issued load dest
module id_ex_hazard_cmp #(
    parameter int REG_W = 5
) (
    input  logic             id_valid,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_memread,
    output logic             lu_hit
);
    assign lu_hit = id_valid & ex_memread & (ex_dest != '0) &
                    ((id_uses_rs & (id_rs == ex_dest)) | (id_uses_rt & (id_rt == ex_dest)));
endmodule

// File: rtl/id_ex_issue_ctrl.sv
// rtl/id_ex_issue_ctrl.sv - ID-stage issue controller: pass/bubble/flush into ID/EX
// Optional statistics counters under `HAZARD_STATS_EN.
module id_ex_issue_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CW_W            = 13,
    parameter int REG_W           = 5,
    parameter int LU_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W           = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    id_ex_issue_ctrl_if.slave bus,
    input  logic              ex_branch_taken,
    input  logic              ext_stall,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);
    issue_state_e     state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [REG_W-1:0] ex_dest_q, ex_dest_d;
    logic             ex_memread_q, ex_memread_d;
    logic [CW_W-1:0]  out_cw;
    logic             out_bubble;
    logic             lu_hit;
`ifdef HAZARD_STATS_EN
    logic             stall_ev, flush_ev;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
`endif

    id_ex_hazard_cmp #(.REG_W(REG_W)) u_cmp (
        .id_valid   (bus.id_valid),
        .id_uses_rs (bus.id_uses_rs),
        .id_uses_rt (bus.id_uses_rt),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .ex_dest    (ex_dest_q),
        .ex_memread (ex_memread_q),
        .lu_hit     (lu_hit)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ex_dest_d    = '0;
        ex_memread_d = 1'b0;
        out_cw       = CW_NOP;
        out_bubble   = 1'b1;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
`ifdef HAZARD_STATS_EN
        stall_ev     = 1'b0;
        flush_ev     = 1'b0;
`endif
        if (ex_branch_taken) begin
            ifid_flush = 1'b1;
`ifdef HAZARD_STATS_EN
            flush_ev   = 1'b1;
`endif
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = 2'(FLUSH_CYCLES - 1);
            end else begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        end else if (ext_stall) begin
            // Downstream is frozen, so the load in EX stays there: keep its shadow.
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            ex_dest_d    = ex_dest_q;
            ex_memread_d = ex_memread_q;
        end else if (state_q == ST_RUN && lu_hit) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
`ifdef HAZARD_STATS_EN
            stall_ev  = 1'b1;
`endif
            if (LU_STALL_CYCLES > 1) begin
                state_d = ST_LU_STALL;
                cnt_d   = 2'(LU_STALL_CYCLES - 1);
            end
        end else if (state_q == ST_LU_STALL) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
`ifdef HAZARD_STATS_EN
            stall_ev  = 1'b1;
`endif
            cnt_d     = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = ST_RUN;
        end else if (state_q == ST_FLUSH) begin
            ifid_flush = 1'b1;
`ifdef HAZARD_STATS_EN
            flush_ev   = 1'b1;
`endif
            cnt_d      = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = ST_RUN;
        end else if (bus.id_valid) begin
            out_cw       = bus.id_ctrl_in;
            out_bubble   = 1'b0;
            ex_dest_d    = bus.id_ctrl_in[CW_RTRD] ? bus.id_rd : bus.id_rt;
            ex_memread_d = bus.id_ctrl_in[CW_MEMREAD];
        end

        if (!reset) begin
            out_cw     = CW_NOP;
            out_bubble = 1'b1;
            pc_hold    = 1'b0;
            ifid_hold  = 1'b0;
            ifid_flush = 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_ev && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_ev && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            cnt_q        <= 2'd0;
            ex_dest_q    <= '0;
            ex_memread_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ex_dest_q    <= ex_dest_d;
            ex_memread_q <= ex_memread_d;
        end
    end

    assign bus.ex_ctrl_out = out_cw;
    assign bus.bubble      = out_bubble;
endmodule

// File: tb/tb_id_ex_issue_ctrl.sv
// tb/tb_id_ex_issue_ctrl.sv - directed bench: default DUT and LU_STALL_CYCLES=3/FLUSH_CYCLES=2 DUT
module tb_id_ex_issue_ctrl;
    localparam logic [12:0] LW  = 13'h082A;
    localparam logic [12:0] ADD = 13'h0148;
    localparam logic [12:0] Z   = 13'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_rs, id_uses_rt, br, st;
    logic [12:0] id_ctrl_in;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        a_ph, a_ih, a_fl, b_ph, b_ih, b_fl;
    int          vectors = 0;
    int          miscompares = 0;
`ifdef HAZARD_STATS_EN
    logic [15:0] a_sc, a_fc, b_sc, b_fc;
`endif

    always #5 clk = ~clk;

    id_ex_issue_ctrl_if #(.CW_W(13), .REG_W(5)) bus_a ();
    id_ex_issue_ctrl_if #(.CW_W(13), .REG_W(5)) bus_b ();

    assign bus_a.id_valid   = id_valid;
    assign bus_a.id_ctrl_in = id_ctrl_in;
    assign bus_a.id_rs      = id_rs;
    assign bus_a.id_rt      = id_rt;
    assign bus_a.id_rd      = id_rd;
    assign bus_a.id_uses_rs = id_uses_rs;
    assign bus_a.id_uses_rt = id_uses_rt;
    assign bus_b.id_valid   = id_valid;
    assign bus_b.id_ctrl_in = id_ctrl_in;
    assign bus_b.id_rs      = id_rs;
    assign bus_b.id_rt      = id_rt;
    assign bus_b.id_rd      = id_rd;
    assign bus_b.id_uses_rs = id_uses_rs;
    assign bus_b.id_uses_rt = id_uses_rt;

    id_ex_issue_ctrl u_dut_a (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_a.slave),
        .ex_branch_taken (br),
        .ext_stall       (st),
        .pc_hold         (a_ph),
        .ifid_hold       (a_ih),
        .ifid_flush      (a_fl)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt       (a_sc),
        .flush_cnt       (a_fc)
`endif
    );

    id_ex_issue_ctrl #(.LU_STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_dut_b (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_b.slave),
        .ex_branch_taken (br),
        .ext_stall       (st),
        .pc_hold         (b_ph),
        .ifid_hold       (b_ih),
        .ifid_flush      (b_fl)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt       (b_sc),
        .flush_cnt       (b_fc)
`endif
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step(input string tag, input bit sel_b,
                        input logic v, input logic [12:0] cw, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urs, input logic urt, input logic b, input logic s,
                        input logic [12:0] e_cw, input logic e_bub, input logic e_ph, input logic e_ih,
                        input logic e_fl);
        logic [16:0] obs, exp;
        id_valid = v; id_ctrl_in = cw; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt; br = b; st = s;
        @(negedge clk);
        obs = sel_b ? {bus_b.ex_ctrl_out, bus_b.bubble, b_ph, b_ih, b_fl}
                    : {bus_a.ex_ctrl_out, bus_a.bubble, a_ph, a_ih, a_fl};
        exp = {e_cw, e_bub, e_ph, e_ih, e_fl};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed={cw,bub,ph,ih,fl}=%h expected=%h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        // ---------------- DUT A: LU_STALL_CYCLES=1, FLUSH_CYCLES=1
        step("a_reset",      0, 1, ADD, 8, 9, 10, 1, 1, 0, 0, Z,   1, 0, 0, 0);
        reset = 1'b1;
        step("a_rel_pass",   0, 1, ADD, 8, 9, 10, 1, 1, 0, 0, ADD, 0, 0, 0, 0);
        step("a_lw",         0, 1, LW, 29, 8, 0,  1, 0, 0, 0, LW,  0, 0, 0, 0);
        step("a_lu_bubble",  0, 1, ADD, 8, 9, 10, 1, 1, 0, 0, Z,   1, 1, 1, 0);
        step("a_lu_issue",   0, 1, ADD, 8, 9, 10, 1, 1, 0, 0, ADD, 0, 0, 0, 0);
        step("a_lw2",        0, 1, LW, 29, 8, 0,  1, 0, 0, 0, LW,  0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step("a_ext_stall", 0, 1, ADD, 8, 9, 10, 1, 1, 0, 1, Z, 1, 1, 1, 0);
        step("a_lu_after_st",0, 1, ADD, 8, 9, 10, 1, 1, 0, 0, Z,   1, 1, 1, 0);
        step("a_issue_st",   0, 1, ADD, 8, 9, 10, 1, 1, 0, 0, ADD, 0, 0, 0, 0);
        step("a_branch",     0, 1, ADD, 8, 9, 10, 1, 1, 1, 0, Z,   1, 0, 0, 1);
        step("a_post_br",    0, 1, ADD, 8, 9, 10, 1, 1, 0, 0, ADD, 0, 0, 0, 0);
        step("a_invalid",    0, 0, ADD, 8, 9, 10, 1, 1, 0, 0, Z,   1, 0, 0, 0);
        step("a_lw_r0",      0, 1, LW, 29, 0, 0,  1, 0, 0, 0, LW,  0, 0, 0, 0);
        step("a_use_r0",     0, 1, ADD, 0, 9, 10, 1, 1, 0, 0, ADD, 0, 0, 0, 0);
        step("a_lw3",        0, 1, LW, 29, 8, 0,  1, 0, 0, 0, LW,  0, 0, 0, 0);
        step("a_no_uses",    0, 1, ADD, 8, 8, 10, 0, 0, 0, 0, ADD, 0, 0, 0, 0);
        step("a_lw4",        0, 1, LW, 29, 8, 0,  1, 0, 0, 0, LW,  0, 0, 0, 0);
        step("a_rt_hit",     0, 1, ADD, 1, 8, 10, 1, 1, 0, 0, Z,   1, 1, 1, 0);
        step("a_rt_issue",   0, 1, ADD, 1, 8, 10, 1, 1, 0, 0, ADD, 0, 0, 0, 0);

        // ---------------- DUT B: LU_STALL_CYCLES=3, FLUSH_CYCLES=2
        reset = 1'b0;
        step("b_reset",      1, 1, LW, 29, 8, 0,  1, 0, 0, 0, Z,   1, 0, 0, 0);
        reset = 1'b1;
        step("b_lw",         1, 1, LW, 29, 8, 0,  1, 0, 0, 0, LW,  0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("b_lu3_bubble", 1, 1, ADD, 8, 9, 10, 1, 1, 0, 0, Z, 1, 1, 1, 0);
        step("b_lu3_issue",  1, 1, ADD, 8, 9, 10, 1, 1, 0, 0, ADD, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
        vectors++;
        assert (b_sc === 16'd3) else begin
            miscompares++;
            $error("FAIL b_stall_cnt observed=%0d expected=3", b_sc);
        end
`endif
        step("b_lw2",        1, 1, LW, 29, 8, 0,  1, 0, 0, 0, LW,  0, 0, 0, 0);
        step("b_lu_start",   1, 1, ADD, 8, 9, 10, 1, 1, 0, 0, Z,   1, 1, 1, 0);
        step("b_br_in_lu",   1, 1, ADD, 8, 9, 10, 1, 1, 1, 0, Z,   1, 0, 0, 1);
        step("b_flush2",     1, 1, ADD, 8, 9, 10, 1, 1, 0, 0, Z,   1, 0, 0, 1);
        step("b_post_flush", 1, 1, ADD, 8, 9, 10, 1, 1, 0, 0, ADD, 0, 0, 0, 0);
        step("b_lw3",        1, 1, LW, 29, 8, 0,  1, 0, 0, 0, LW,  0, 0, 0, 0);
        step("b_lu_start2",  1, 1, ADD, 8, 9, 10, 1, 1, 0, 0, Z,   1, 1, 1, 0);
        reset = 1'b0;
        step("b_mid_reset",  1, 1, ADD, 8, 9, 10, 1, 1, 0, 0, Z,   1, 0, 0, 0);
        reset = 1'b1;
        step("b_after_rst",  1, 1, ADD, 8, 9, 10, 1, 1, 0, 0, ADD, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
